// File: rtl/song_editor_multi.sv
// Multi-lane song editor: records a LANES x STEPS note pattern from button pulses,
// with per-lane cursors, backspace and a swept clear. Optional lap-wrap mode: SONG_EDITOR_WRAP_EN.
module song_editor_multi #(
    parameter int                     LANES = 2,
    parameter int                     STEPS = 32,
    parameter logic [LANES*STEPS-1:0] INIT  = {32'hAAAAAAAA, 32'hCCCCCCCC}
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       edit_en,
    input  logic [1:0]                 note_pulse,
    input  logic                       lane_next_pulse,
    input  logic                       back_pulse,
    input  logic                       clear_pulse,
    output logic [LANES*STEPS-1:0]     song,
    output logic [$clog2(LANES)-1:0]   cur_lane,
    output logic [$clog2(STEPS)-1:0]   position,
    output logic [LANES-1:0]           full,
    output logic                       busy
);
    localparam int            LW        = $clog2(LANES);
    localparam int            SW        = $clog2(STEPS);
    localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EDIT,
        S_CLEAR
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [LANES*STEPS-1:0]   r_song;
    logic [SW-1:0]            r_cursor [LANES];
    logic [LANES-1:0]         r_full;
    logic [LW-1:0]            r_lane;
    logic [SW-1:0]            r_idx;

    logic                     w_do_clear;
    logic                     w_do_next;
    logic                     w_do_back;
    logic                     w_do_note;
    logic [SW-1:0]            w_cur;
    logic [SW-1:0]            w_cur_inc;
    logic                     w_full;
    logic [LW+SW-1:0]         w_wr_idx;
    logic [LW+SW-1:0]         w_back_idx;

    assign w_cur      = r_cursor[r_lane];
    assign w_cur_inc  = w_cur + 1'b1;
    assign w_full     = r_full[r_lane];
    assign w_wr_idx   = {r_lane, w_cur};
    assign w_back_idx = {r_lane, w_cur_inc};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // One action per cycle in EDIT: clear > lane_next > back > note.
    always_comb begin
        w_state_nxt = r_state;
        w_do_clear  = 1'b0;
        w_do_next   = 1'b0;
        w_do_back   = 1'b0;
        w_do_note   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (edit_en) w_state_nxt = S_EDIT;
            end
            S_EDIT: begin
                if (!edit_en) begin
                    w_state_nxt = S_IDLE;
                end else if (clear_pulse) begin
                    w_state_nxt = S_CLEAR;
                    w_do_clear  = 1'b1;
                end else if (lane_next_pulse) begin
                    w_do_next = 1'b1;
                end else if (back_pulse) begin
                    w_do_back = 1'b1;
                end else if (note_pulse[0] ^ note_pulse[1]) begin
`ifdef SONG_EDITOR_WRAP_EN
                    w_do_note = 1'b1;
`else
                    w_do_note = !w_full;
`endif
                end
            end
            S_CLEAR: begin
                if (r_idx == '0) w_state_nxt = edit_en ? S_EDIT : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_song <= INIT;
            for (int l = 0; l < LANES; l++) r_cursor[l] <= LAST_STEP;
            r_full <= '0;
            r_lane <= '0;
            r_idx  <= LAST_STEP;
        end else begin
            if (w_do_clear) r_idx <= LAST_STEP;

            // Sweep restores one step of every lane per cycle, top step first.
            if (r_state == S_CLEAR) begin
                for (int l = 0; l < LANES; l++) begin
                    r_song[{LW'(l), r_idx}] <= INIT[{LW'(l), r_idx}];
                end
                r_idx <= r_idx - 1'b1;
                if (r_idx == '0) begin
                    for (int l = 0; l < LANES; l++) r_cursor[l] <= LAST_STEP;
                    r_full <= '0;
                    r_lane <= '0;
                end
            end

            if (w_do_next) begin
                r_lane <= (r_lane == LAST_LANE) ? '0 : r_lane + 1'b1;
            end

            if (w_do_note) begin
                r_song[w_wr_idx] <= note_pulse[1];
                if (w_cur == '0) begin
                    r_full[r_lane] <= 1'b1;
`ifdef SONG_EDITOR_WRAP_EN
                    r_cursor[r_lane] <= LAST_STEP;
`endif
                end else begin
                    r_cursor[r_lane] <= w_cur - 1'b1;
                end
            end

            if (w_do_back) begin
`ifdef SONG_EDITOR_WRAP_EN
                if (w_cur != LAST_STEP) begin
                    r_cursor[r_lane]   <= w_cur_inc;
                    r_song[w_back_idx] <= INIT[w_back_idx];
                end
`else
                if (w_full) begin
                    r_full[r_lane]   <= 1'b0;
                    r_song[w_wr_idx] <= INIT[w_wr_idx];
                end else if (w_cur != LAST_STEP) begin
                    r_cursor[r_lane]   <= w_cur_inc;
                    r_song[w_back_idx] <= INIT[w_back_idx];
                end
`endif
            end
        end
    end

    assign song     = r_song;
    assign cur_lane = r_lane;
    assign position = w_cur;
    assign full     = r_full;
    assign busy     = (r_state == S_CLEAR);

endmodule

// File: tb/tb_song_editor_multi.sv
// Self-checking bench for song_editor_multi: vector table, directed corner sequences
// and a randomized run against a behavioural array-based model.
module tb_song_editor_multi;
    localparam int          LANES = 2;
    localparam int          STEPS = 32;
    localparam logic [63:0] INIT  = {32'hAAAAAAAA, 32'hCCCCCCCC};

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        edit_en = 1'b0;
    logic [1:0]  note_pulse = 2'b00;
    logic        lane_next_pulse = 1'b0;
    logic        back_pulse = 1'b0;
    logic        clear_pulse = 1'b0;
    logic [63:0] song;
    logic        cur_lane;
    logic [4:0]  position;
    logic [1:0]  full;
    logic        busy;

    song_editor_multi #(.LANES(LANES), .STEPS(STEPS), .INIT(INIT)) dut (
        .clk(clk), .nrst(nrst), .edit_en(edit_en), .note_pulse(note_pulse),
        .lane_next_pulse(lane_next_pulse), .back_pulse(back_pulse),
        .clear_pulse(clear_pulse), .song(song), .cur_lane(cur_lane),
        .position(position), .full(full), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: mode 0=idle 1=edit 2=clearing, m_cnt = sweep steps remaining.
    int          m_mode;
    int          m_cnt;
    logic [63:0] m_song;
    int          m_cur [LANES];
    logic [1:0]  m_full;
    int          m_lane;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic m_reset();
        m_mode = 0;
        m_cnt  = 0;
        m_song = INIT;
        for (int l = 0; l < LANES; l++) m_cur[l] = STEPS - 1;
        m_full = '0;
        m_lane = 0;
    endtask

    task automatic m_step(input logic e, input logic [1:0] n, input logic nx, input logic bk,
                          input logic cl);
        int c;
        int b;
        c = m_cur[m_lane];
        b = m_lane * STEPS;
        case (m_mode)
            0: if (e) m_mode = 1;
            1: begin
                if (!e) m_mode = 0;
                else if (cl) begin
                    m_mode = 2;
                    m_cnt  = STEPS;
                end else if (nx) m_lane = (m_lane + 1) % LANES;
                else if (bk) begin
`ifdef SONG_EDITOR_WRAP_EN
                    if (c < STEPS - 1) begin
                        m_cur[m_lane] = c + 1;
                        m_song[b+c+1] = INIT[b+c+1];
                    end
`else
                    if (m_full[m_lane]) begin
                        m_full[m_lane] = 1'b0;
                        m_song[b]      = INIT[b];
                    end else if (c < STEPS - 1) begin
                        m_cur[m_lane] = c + 1;
                        m_song[b+c+1] = INIT[b+c+1];
                    end
`endif
                end else if (n == 2'b01 || n == 2'b10) begin
`ifdef SONG_EDITOR_WRAP_EN
                    m_song[b+c] = n[1];
                    if (c == 0) begin
                        m_cur[m_lane]  = STEPS - 1;
                        m_full[m_lane] = 1'b1;
                    end else m_cur[m_lane] = c - 1;
`else
                    if (!m_full[m_lane]) begin
                        m_song[b+c] = n[1];
                        if (c == 0) m_full[m_lane] = 1'b1;
                        else m_cur[m_lane] = c - 1;
                    end
`endif
                end
            end
            default: begin
                m_cnt--;
                for (int l = 0; l < LANES; l++) m_song[l*STEPS+m_cnt] = INIT[l*STEPS+m_cnt];
                if (m_cnt == 0) begin
                    for (int l = 0; l < LANES; l++) m_cur[l] = STEPS - 1;
                    m_full = '0;
                    m_lane = 0;
                    m_mode = e ? 1 : 0;
                end
            end
        endcase
    endtask

    task automatic step(input logic e, input logic [1:0] n, input logic nx, input logic bk,
                        input logic cl);
        @(negedge clk);
        edit_en = e; note_pulse = n; lane_next_pulse = nx; back_pulse = bk; clear_pulse = cl;
        m_step(e, n, nx, bk, cl);
        @(posedge clk);
        #1;
        check("model_song", song, m_song);
        check("model_lane", 64'(cur_lane), 64'(m_lane));
        check("model_pos", 64'(position), 64'(m_cur[m_lane]));
        check("model_full", 64'(full), 64'(m_full));
        check("model_busy", 64'(busy), 64'(m_mode == 2));
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0;
        edit_en = 1'b0; note_pulse = 2'b00; lane_next_pulse = 1'b0; back_pulse = 1'b0;
        clear_pulse = 1'b0;
        m_reset();
        @(negedge clk);
        nrst = 1'b1;
    endtask

    typedef struct {
        logic        e;
        logic [1:0]  n;
        logic        nx;
        logic        bk;
        logic        cl;
        logic [4:0]  pos;
        logic        lane;
        logic [1:0]  fl;
        logic [63:0] sg;
    } vec_t;

    vec_t tbl [18];

    initial begin
        int   busy_cnt;
        logic e_r;

        tbl[0]  = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'd31, 1'b0, 2'b00, 64'hAAAAAAAA_CCCCCCCC};
        tbl[1]  = '{1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 5'd30, 1'b0, 2'b00, 64'hAAAAAAAA_CCCCCCCC};
        tbl[2]  = '{1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 5'd29, 1'b0, 2'b00, 64'hAAAAAAAA_8CCCCCCC};
        tbl[3]  = '{1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 5'd31, 1'b1, 2'b00, 64'hAAAAAAAA_8CCCCCCC};
        tbl[4]  = '{1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 5'd30, 1'b1, 2'b00, 64'h2AAAAAAA_8CCCCCCC};
        tbl[5]  = '{1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 5'd29, 1'b0, 2'b00, 64'h2AAAAAAA_8CCCCCCC};
        tbl[6]  = '{1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 5'd30, 1'b0, 2'b00, 64'h2AAAAAAA_CCCCCCCC};
        tbl[7]  = '{1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 5'd31, 1'b0, 2'b00, 64'h2AAAAAAA_CCCCCCCC};
        tbl[8]  = '{1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 5'd31, 1'b0, 2'b00, 64'h2AAAAAAA_CCCCCCCC};
        tbl[9]  = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 5'd31, 1'b0, 2'b00, 64'h2AAAAAAA_CCCCCCCC};
        tbl[10] = '{1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 5'd31, 1'b0, 2'b00, 64'h2AAAAAAA_CCCCCCCC};
        tbl[11] = '{1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 5'd31, 1'b0, 2'b00, 64'h2AAAAAAA_CCCCCCCC};
        tbl[12] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 5'd31, 1'b0, 2'b00, 64'h2AAAAAAA_CCCCCCCC};
        tbl[13] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 5'd31, 1'b0, 2'b00, 64'h2AAAAAAA_CCCCCCCC};
        tbl[14] = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'd31, 1'b0, 2'b00, 64'h2AAAAAAA_CCCCCCCC};
        tbl[15] = '{1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 5'd30, 1'b0, 2'b00, 64'h2AAAAAAA_4CCCCCCC};
        tbl[16] = '{1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 5'd30, 1'b1, 2'b00, 64'h2AAAAAAA_4CCCCCCC};
        tbl[17] = '{1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 5'd29, 1'b1, 2'b00, 64'h6AAAAAAA_4CCCCCCC};

        m_reset();
        repeat (2) @(negedge clk);
        check("rst_song", song, INIT);
        check("rst_pos", 64'(position), 64'd31);
        check("rst_lane", 64'(cur_lane), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        nrst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].e, tbl[i].n, tbl[i].nx, tbl[i].bk, tbl[i].cl);
            check($sformatf("row%0d_song", i), song, tbl[i].sg);
            check($sformatf("row%0d_pos", i), 64'(position), 64'(tbl[i].pos));
            check($sformatf("row%0d_lane", i), 64'(cur_lane), 64'(tbl[i].lane));
            check($sformatf("row%0d_full", i), 64'(full), 64'(tbl[i].fl));
        end

        // Fill lane 0 completely, then one extra write and a backspace.
        do_reset();
        step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        check("fill32_song", song, 64'hAAAAAAAA_FFFFFFFF);
        check("fill32_full", 64'(full), 64'd1);
`ifdef SONG_EDITOR_WRAP_EN
        check("fill32_pos", 64'(position), 64'd31);
        step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        check("w33_song", song, 64'hAAAAAAAA_7FFFFFFF);
        check("w33_pos", 64'(position), 64'd30);
        check("w33_full", 64'(full), 64'd1);
        step(1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        check("back_song", song, 64'hAAAAAAAA_FFFFFFFF);
        check("back_pos", 64'(position), 64'd31);
        check("back_full", 64'(full), 64'd1);
`else
        check("fill32_pos", 64'(position), 64'd0);
        step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        check("w33_song", song, 64'hAAAAAAAA_FFFFFFFF);
        check("w33_pos", 64'(position), 64'd0);
        check("w33_full", 64'(full), 64'd1);
        step(1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        check("back_song", song, 64'hAAAAAAAA_FFFFFFFE);
        check("back_pos", 64'(position), 64'd0);
        check("back_full", 64'(full), 64'd0);
`endif

        // Clear sweep with pulses hammering during the sweep.
        step(1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        busy_cnt = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            busy_cnt++;
            step(1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        check("clr_busy_cycles", 64'(busy_cnt), 64'd32);
        check("clr_song", song, INIT);
        check("clr_pos", 64'(position), 64'd31);
        check("clr_full", 64'(full), 64'd0);
        check("clr_lane", 64'(cur_lane), 64'd0);
        check("clr_busy_end", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of a sweep.
        step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        repeat (5) step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        nrst = 1'b0;
        m_reset();
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_song", song, INIT);
        check("mid_rst_pos", 64'(position), 64'd31);
        @(negedge clk);
        nrst = 1'b1;

        // Randomized run against the model.
        do_reset();
        e_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) e_r = ~e_r;
            step(e_r,
                 ($urandom_range(0, 9) < 6) ? 2'($urandom_range(0, 3)) : 2'b00,
                 1'($urandom_range(0, 99) < 3),
                 1'($urandom_range(0, 99) < 10),
                 1'($urandom_range(0, 199) < 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
